// File: rtl/maxnet_driver_pkg.sv
// Shared definitions for the Maxnet initiator: widths, operand count and FSM state encoding.
package maxnet_driver_pkg;

  localparam int MAXNET_WIDTH = 5;
  localparam int IDX_W        = 2;
  localparam int NUM_OPS      = 4;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_OUT     = 2'd3
  } state_e;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/maxnet_driver_if.sv
// Bundles the sample input stream, the Maxnet start/done bus and the result output stream.
interface maxnet_driver_if
  import maxnet_driver_pkg::*;
#(
  parameter int WIDTH = MAXNET_WIDTH
);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;

  logic             start;
  logic [WIDTH-1:0] X1;
  logic [WIDTH-1:0] X2;
  logic [WIDTH-1:0] X3;
  logic [WIDTH-1:0] X4;
  logic             done;
  logic [WIDTH-1:0] result;

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  idx_t             m_idx;
  logic             m_err;

  // Driver side.
  modport master (
    input  s_valid, s_data, done, result, m_ready,
    output s_ready, start, X1, X2, X3, X4, m_valid, m_data, m_idx, m_err
  );

  // Environment side: sample source, Maxnet core and result sink.
  modport slave (
    output s_valid, s_data, done, result, m_ready,
    input  s_ready, start, X1, X2, X3, X4, m_valid, m_data, m_idx, m_err
  );

endinterface

// File: rtl/maxnet_idx_match.sv
// Combinational comparator: finds the lowest-index operand equal to the Maxnet result.
module maxnet_idx_match
  import maxnet_driver_pkg::*;
#(
  parameter int WIDTH = MAXNET_WIDTH
) (
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] x4,
  output logic             hit,
  output idx_t             idx
);

  // NOTE: every output gets a default before the if-chain so no path leaves a value unassigned (no latch).
  always_comb begin
    hit = 1'b1;
    idx = '0;
    // Priority order makes equal maxima resolve to the lowest index.
    if (x1 == result)      idx = 2'd0;
    else if (x2 == result) idx = 2'd1;
    else if (x3 == result) idx = 2'd2;
    else if (x4 == result) idx = 2'd3;
    else                   hit = 1'b0;
  end

endmodule

// File: rtl/maxnet_driver.sv
// Maxnet initiator: collects four samples, pulses start, waits for done, returns value and index.
// Optional WAIT-state timeout is enabled by defining MAXNET_DRIVER_TIMEOUT_EN.
module maxnet_driver
  import maxnet_driver_pkg::*;
#(
  parameter int WIDTH          = MAXNET_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst,
  maxnet_driver_if.master bus
);

  state_e           state, state_d;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] x_q [NUM_OPS];
  logic [WIDTH-1:0] m_data_q;
  idx_t             m_idx_q;
  logic             m_err_q;
  logic             hit;
  idx_t             hit_idx;

`ifdef MAXNET_DRIVER_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;
  // Counter starts at 0 in the first WAIT cycle, so the limit is hit in WAIT cycle TIMEOUT_CYCLES.
  assign timeout = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`endif

  maxnet_idx_match #(.WIDTH(WIDTH)) u_match (
    .result (bus.result),
    .x1     (x_q[0]),
    .x2     (x_q[1]),
    .x3     (x_q[2]),
    .x4     (x_q[3]),
    .hit    (hit),
    .idx    (hit_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_COLLECT: if (bus.s_valid && cnt == 2'd3) state_d = ST_START;
      ST_START:   state_d = ST_WAIT;
`ifdef MAXNET_DRIVER_TIMEOUT_EN
      ST_WAIT:    if (bus.done || timeout) state_d = ST_OUT;
`else
      ST_WAIT:    if (bus.done) state_d = ST_OUT;
`endif
      ST_OUT:     if (bus.m_ready) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // NOTE: operand registers are reset explicitly because X1..X4 must read 0 after reset, not just be "don't care".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      m_data_q <= '0;
      m_idx_q  <= '0;
      m_err_q  <= 1'b0;
      for (int i = 0; i < NUM_OPS; i++) x_q[i] <= '0;
`ifdef MAXNET_DRIVER_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values of its peers.
      unique case (state)
        ST_COLLECT: begin
          if (bus.s_valid) begin
            x_q[cnt] <= bus.s_data;
            cnt      <= cnt + 2'd1;
          end
        end
        ST_START: begin
`ifdef MAXNET_DRIVER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (bus.done) begin
            m_data_q <= bus.result;
            m_idx_q  <= hit_idx;
            m_err_q  <= ~hit;
          end
`ifdef MAXNET_DRIVER_TIMEOUT_EN
          else if (timeout) begin
            m_data_q <= '0;
            m_idx_q  <= '0;
            m_err_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_OUT: begin
          if (bus.m_ready) m_err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags decode straight from the state register; input and output phases never overlap.
  assign bus.s_ready = (state == ST_COLLECT);
  assign bus.start   = (state == ST_START);
  assign bus.m_valid = (state == ST_OUT);
  assign bus.m_data  = m_data_q;
  assign bus.m_idx   = m_idx_q;
  assign bus.m_err   = m_err_q;
  assign bus.X1      = x_q[0];
  assign bus.X2      = x_q[1];
  assign bus.X3      = x_q[2];
  assign bus.X4      = x_q[3];

endmodule

// File: tb/tb_maxnet_driver.sv
// Directed bench for maxnet_driver: the bench plays sample source, Maxnet core and result sink.
module tb_maxnet_driver;
  import maxnet_driver_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  maxnet_driver_if #(.WIDTH(5)) bus ();

  maxnet_driver #(.WIDTH(5), .TIMEOUT_CYCLES(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Offers one sample at a falling edge; returns at the falling edge after its handshake.
  task automatic push(input logic [4:0] v);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      total++; bad++;
      $display("FAIL push_timeout s_ready=%0b wanted 1 within 50 cycles", bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // Four samples, start-pulse checks, then a done pulse dly cycles after start; ends in OUT.
  task automatic run_batch(input string tag, input logic [4:0] a, b, c, d,
                           input bit gap, input logic [4:0] res, input int dly);
    logic [4:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      if (gap && i > 0) @(negedge clk);
      push(v[i]);
    end
    total++;
    if (bus.start !== 1'b1) begin bad++; $display("FAIL %s_start got=%b want=1", tag, bus.start); end
    @(negedge clk);
    total++;
    if (bus.start !== 1'b0) begin bad++; $display("FAIL %s_start_pulse got=%b want=0", tag, bus.start); end
    repeat (dly - 1) @(negedge clk);
    bus.done   = 1'b1;
    bus.result = res;
    @(negedge clk);
    bus.done   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.s_ready, bus.start, bus.m_valid, bus.m_err} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags got=%b want=1000", {bus.s_ready, bus.start, bus.m_valid, bus.m_err});
    end
    total++;
    if ({bus.m_data, bus.m_idx, bus.X1, bus.X2, bus.X3, bus.X4} !== '0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {bus.m_data, bus.m_idx, bus.X1, bus.X2, bus.X3, bus.X4});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bus.m_ready = 1'b1;
    run_batch("basic", 5'd2, 5'd7, 5'd1, 5'd6, 1'b0, 5'd7, 10);
    total++;
    if ({bus.m_valid, bus.m_data, bus.m_idx, bus.m_err} !== {1'b1, 5'd7, 2'd1, 1'b0}) begin
      bad++; $display("FAIL basic_out got v=%b d=%0d i=%0d e=%b want v=1 d=7 i=1 e=0",
                      bus.m_valid, bus.m_data, bus.m_idx, bus.m_err);
    end
    @(negedge clk);
    total++;
    if ({bus.m_valid, bus.s_ready} !== 2'b01) begin
      bad++; $display("FAIL basic_return got m_valid/s_ready=%b want 01", {bus.m_valid, bus.s_ready});
    end
  endtask

  task automatic test_gaps();
    run_batch("gaps", 5'd3, 5'd3, 5'd4, 5'd1, 1'b1, 5'd4, 4);
    total++;
    if ({bus.X1, bus.X2, bus.X3, bus.X4} !== {5'd3, 5'd3, 5'd4, 5'd1}) begin
      bad++; $display("FAIL gaps_operands got=%0d,%0d,%0d,%0d want=3,3,4,1", bus.X1, bus.X2, bus.X3, bus.X4);
    end
    total++;
    if ({bus.m_data, bus.m_idx, bus.m_err} !== {5'd4, 2'd2, 1'b0}) begin
      bad++; $display("FAIL gaps_out got d=%0d i=%0d e=%b want d=4 i=2 e=0", bus.m_data, bus.m_idx, bus.m_err);
    end
    @(negedge clk);
  endtask

  task automatic test_tie_and_nomatch();
    run_batch("tie", 5'd6, 5'd6, 5'd3, 5'd1, 1'b0, 5'd6, 3);
    total++;
    if ({bus.m_data, bus.m_idx, bus.m_err} !== {5'd6, 2'd0, 1'b0}) begin
      bad++; $display("FAIL tie_out got d=%0d i=%0d e=%b want d=6 i=0 e=0", bus.m_data, bus.m_idx, bus.m_err);
    end
    @(negedge clk);
    run_batch("nomatch", 5'd6, 5'd6, 5'd3, 5'd1, 1'b0, 5'd5, 3);
    total++;
    if ({bus.m_valid, bus.m_data, bus.m_idx, bus.m_err} !== {1'b1, 5'd5, 2'd0, 1'b1}) begin
      bad++; $display("FAIL nomatch_out got v=%b d=%0d i=%0d e=%b want v=1 d=5 i=0 e=1",
                      bus.m_valid, bus.m_data, bus.m_idx, bus.m_err);
    end
    @(negedge clk);
    total++;
    if (bus.m_err !== 1'b0) begin bad++; $display("FAIL nomatch_err_clear got=%b want=0", bus.m_err); end
  endtask

  // done during the START cycle must be ignored; the real done then selects index 3.
  task automatic test_early_done();
    push(5'd8); push(5'd1); push(5'd2); push(5'd3);
    bus.done   = 1'b1;
    bus.result = 5'd8;
    @(negedge clk);
    bus.done   = 1'b0;
    @(negedge clk);
    total++;
    if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL early_done_ignored m_valid=%b want=0", bus.m_valid); end
    bus.done   = 1'b1;
    bus.result = 5'd3;
    @(negedge clk);
    bus.done   = 1'b0;
    total++;
    if ({bus.m_valid, bus.m_data, bus.m_idx} !== {1'b1, 5'd3, 2'd3}) begin
      bad++; $display("FAIL early_done_out got v=%b d=%0d i=%0d want v=1 d=3 i=3", bus.m_valid, bus.m_data, bus.m_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.m_ready = 1'b0;
    run_batch("bp", 5'd9, 5'd2, 5'd31, 5'd31, 1'b0, 5'd31, 3);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.m_valid, bus.s_ready, bus.m_data, bus.m_idx} !== {1'b1, 1'b0, 5'd31, 2'd2}) begin
        bad++; $display("FAIL bp_hold cycle=%0d got v=%b sr=%b d=%0d i=%0d want v=1 sr=0 d=31 i=2",
                        i, bus.m_valid, bus.s_ready, bus.m_data, bus.m_idx);
      end
      @(negedge clk);
    end
    bus.m_ready = 1'b1;
    total++;
    if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL bp_no_overlap s_ready=%b want=0", bus.s_ready); end
    @(negedge clk);
    total++;
    if ({bus.m_valid, bus.s_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_release got m_valid/s_ready=%b want 01", {bus.m_valid, bus.s_ready});
    end
  endtask

  task automatic test_reset_in_wait();
    push(5'd5); push(5'd6); push(5'd7); push(5'd8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.start, bus.m_valid, bus.s_ready, bus.X1} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
      bad++; $display("FAIL rst_wait got st=%b v=%b sr=%b x1=%0d want st=0 v=0 sr=1 x1=0",
                      bus.start, bus.m_valid, bus.s_ready, bus.X1);
    end
    @(negedge clk);
    rst = 1'b0;
    run_batch("after_rst", 5'd1, 5'd2, 5'd3, 5'd4, 1'b0, 5'd4, 2);
    total++;
    if ({bus.m_valid, bus.m_data, bus.m_idx, bus.m_err} !== {1'b1, 5'd4, 2'd3, 1'b0}) begin
      bad++; $display("FAIL after_rst_out got v=%b d=%0d i=%0d e=%b want v=1 d=4 i=3 e=0",
                      bus.m_valid, bus.m_data, bus.m_idx, bus.m_err);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n = 0;
    bus.m_ready = 1'b1;
    push(5'd10); push(5'd11); push(5'd12); push(5'd13);
`ifdef MAXNET_DRIVER_TIMEOUT_EN
    while (!bus.m_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n - 1 !== 255) begin bad++; $display("FAIL timeout_cycles got=%0d want=255", n - 1); end
    total++;
    if ({bus.m_valid, bus.m_data, bus.m_idx, bus.m_err} !== {1'b1, 5'd0, 2'd0, 1'b1}) begin
      bad++; $display("FAIL timeout_out got v=%b d=%0d i=%0d e=%b want v=1 d=0 i=0 e=1",
                      bus.m_valid, bus.m_data, bus.m_idx, bus.m_err);
    end
    @(negedge clk);
    bus.done   = 1'b1;
    bus.result = 5'd10;
    @(negedge clk);
    bus.done   = 1'b0;
    total++;
    if ({bus.m_valid, bus.s_ready, bus.m_err} !== 3'b010) begin
      bad++; $display("FAIL stray_done got v/sr/e=%b want 010", {bus.m_valid, bus.s_ready, bus.m_err});
    end
`else
    while (!bus.m_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
      bad++; $display("FAIL wait_forever got v=%b sr=%b after %0d cycles want v=0 sr=0", bus.m_valid, bus.s_ready, n);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL wait_exit_rst s_ready=%b want=1", bus.s_ready); end
`endif
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.done    = 1'b0;
    bus.result  = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_tie_and_nomatch();
    test_early_done();
    test_backpressure();
    test_reset_in_wait();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
